// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, go/over handshake, exposed state.
// Define SIGNED_DIV_EN for two's-complement operands (magnitude datapath plus sign fix-up on exit).
`timescale 1ns/1ps
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             over,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        BAD  = 2'd3
    } state_t;

    state_t           cur, nxt;
    logic [WIDTH-1:0] r_q, w_q, dsr_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] r_next, w_next;
    logic [WIDTH-1:0] a_mag, b_mag, quot_fix, rem_fix;
    logic             last_step;

`ifdef SIGNED_DIV_EN
    logic qneg_q, rneg_q;

    assign a_mag    = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag    = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign quot_fix = qneg_q ? -w_next : w_next;
    assign rem_fix  = rneg_q ? -r_next : r_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (cur == IDLE && go) begin
            qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q <= dividend[WIDTH-1];
        end
    end
`else
    assign a_mag    = dividend;
    assign b_mag    = divisor;
    assign quot_fix = w_next;
    assign rem_fix  = r_next;
`endif

    // Trial subtraction is done as a WIDTH+1-bit compare; the low-WIDTH difference always fits.
    always_comb begin
        shifted = {r_q, w_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dsr_q});
        r_next  = fits ? (shifted[WIDTH-1:0] - dsr_q) : shifted[WIDTH-1:0];
        w_next  = {w_q[WIDTH-2:0], fits};
    end

    assign last_step = (cnt_q == CW'(1));
    assign state     = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (go) nxt = (divisor == '0) ? DONE : CALC;
            CALC:    if (last_step) nxt = DONE;
            DONE:    if (!go) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            w_q   <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            quot  <= '0;
            rem   <= '0;
            over  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (cur)
                IDLE: begin
                    if (go) begin
                        dsr_q <= b_mag;
                        if (divisor == '0) begin
                            quot <= '1;
                            rem  <= dividend;
                            dbz  <= 1'b1;
                            over <= 1'b1;
                        end else begin
                            r_q   <= '0;
                            w_q   <= a_mag;
                            cnt_q <= CW'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_next;
                    w_q   <= w_next;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_step) begin
                        quot <= quot_fix;
                        rem  <= rem_fix;
                        over <= 1'b1;
                        dbz  <= 1'b0;
                    end
                end
                DONE: if (!go) over <= 1'b0;
                default: over <= 1'b0;
            endcase
        end
    end
endmodule
